uart_receiver: RTL and testbench
================================

# uart_receiver

UART receive path: a baud-rate tick generator feeding an oversampling serial-to-parallel receiver. It converts an asynchronous 8N1 line (LSB first) into a parallel byte plus a one-cycle done strobe. It sits between the board RX pin and the byte-consuming logic (FIFO/ALU interface) in the UART module.

## Interface
- FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 19200: line baud rate.
- N, 10: width of the tick divider counter; must satisfy 2^N > FREQ/(BAUD_RATE*16).
- DATA_WIDTH, 8: data bits per frame.
- STOP_TICKS, 16: oversample ticks per stop bit (16 = 1 stop bit).
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- i_rx  in  1  serial line, idle high, asynchronous to clk.
- o_tick  out  1  oversample tick, one-clk pulse at 16x baud.
- o_rx_done  out  1  one-clk pulse when a frame completes.
- o_data_byte  out  DATA_WIDTH  last received byte; held until the next frame completes.
- o_frame_err  out  1  one-clk pulse, coincident with o_rx_done, when the stop bit sampled low.

## Operation
- Divisor: DIV = FREQ/(BAUD_RATE*16), integer division (325 at the defaults). The counter counts 0..DIV-1. o_tick is high for the single cycle in which the counter equals DIV-1; the counter then wraps to 0.
- i_rx passes through a 2-flop synchronizer (reset value 1). Only the synchronized signal is used.
- FSM states: IDLE, START, DATA, STOP. It holds a 4-bit tick counter s, a 3-bit bit counter n and a DATA_WIDTH shift register b.
- IDLE: on synchronized rx = 0, go to START with s = 0.
- START: on each tick, s++. At s = 7 (mid start bit): if rx = 0, go to DATA with s = 0, n = 0. If rx = 1, the start is a glitch: return to IDLE.
- DATA: on each tick, s++. At s = 15: shift b right with rx entering at the MSB (LSB-first reception), set s = 0, and n++. After DATA_WIDTH bits, go to STOP.
- STOP: on each tick, s++. At s = STOP_TICKS-1: load o_data_byte from b, pulse o_rx_done, pulse o_frame_err if rx = 0, then go to IDLE. The byte is delivered even when a framing error is flagged.
- Counters and state advance only on cycles where o_tick = 1, except the IDLE start detection, which acts on any clock.

## Timing
- Reset values: divider counter 0, o_tick 0, state IDLE, s/n/b 0, o_data_byte 0, o_rx_done 0, o_frame_err 0, synchronizer 1.
- Reset asserted mid-frame aborts the frame at the next edge. No o_rx_done is produced, and o_data_byte returns to 0.
- Bit period is 16*DIV clocks (5200 clk = 52.0 µs at the defaults). Mid-bit sampling tolerates ±3% baud mismatch.
- Latency: o_rx_done rises about 2 clk (synchronizer) plus the start-detect tick alignment after the middle of the stop bit. Worst case is one tick period plus 3 clk beyond the mid-stop point.
- o_rx_done and o_frame_err are registered and high for exactly 1 clk. o_data_byte updates on the same edge that raises o_rx_done.
- Back-to-back frames: a start edge immediately after the stop sample must be accepted, because IDLE re-arms on the cycle after o_rx_done.

## Structure
- Shared package (uart_pkg): state encoding (IDLE/START/DATA/STOP), the default FREQ/BAUD_RATE constants, and a function computing DIV.
- Sub-module br_generator (clk, reset, o_tick; parameters FREQ, BAUD_RATE, N) is instantiated in uart_receiver. The synchronizer and FSM live in the top module.

## Test plan
- Reset for 20 ns, then count clocks between o_tick pulses -> exactly 325, each pulse 1 clk wide.
- Drive idle 52080 ns, start bit, data 0xD6 LSB first (0,1,1,0,1,0,1,1), then a stop bit, each bit 52080 ns -> o_data_byte = 0xD6, exactly one o_rx_done pulse, o_frame_err = 0.
- Two back-to-back frames 0x55 then 0xA3 with no idle gap -> two o_rx_done pulses, with bytes 0x55 then 0xA3.
- Low glitch of 2 µs on an idle line -> no o_rx_done, FSM back in IDLE, a following 0x3C frame received correctly.
- Frame 0x81 with the stop bit driven low -> o_data_byte = 0x81, o_rx_done and o_frame_err pulse together.
- Assert reset during data bit 4 of a frame -> no o_rx_done, o_data_byte = 0, next full frame 0xF0 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// default clocking constants and the oversample divisor calculation.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int unsigned DEF_FREQ      = 100_000_000;
   localparam int unsigned DEF_BAUD_RATE = 19_200;

   // Clocks per oversample tick (16x baud), truncating division.
   function automatic int unsigned calc_div(input int unsigned freq, input int unsigned baud);
      return freq / (baud * 16);
   endfunction

endpackage

// File: rtl/br_generator.sv
// Oversample tick generator: free-running 0..DIV-1 counter, o_tick high
// for the single cycle the counter sits at DIV-1.
module br_generator
   import uart_pkg::*;
#(
   parameter int unsigned FREQ      = DEF_FREQ,
   parameter int unsigned BAUD_RATE = DEF_BAUD_RATE,
   parameter int unsigned N         = 10
) (
   input  logic clk,
   input  logic reset,
   output logic o_tick
);

   localparam int unsigned DIV  = calc_div(FREQ, BAUD_RATE);
   localparam logic [N-1:0] LAST = N'(DIV - 1);

   logic [N-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + N'(1);
   end

   assign o_tick = (cnt == LAST);

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop input synchronizer plus a 16x oversampling
// FSM that samples mid-bit and delivers a byte with a one-cycle done strobe.
//
// state | meaning
// IDLE  | line idle, waiting for a low level on synchronized rx
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling DATA_WIDTH data bits at mid-bit, LSB first
// STOP  | waiting to mid stop bit, then deliver byte and framing status
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned FREQ       = DEF_FREQ,
   parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
   parameter int unsigned N          = 10,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_TICKS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_rx,
   output logic                  o_tick,
   output logic                  o_rx_done,
   output logic [DATA_WIDTH-1:0] o_data_byte,
   output logic                  o_frame_err
);

   localparam logic [2:0] LAST_BIT  = 3'(DATA_WIDTH - 1);
   localparam logic [3:0] STOP_LAST = 4'(STOP_TICKS - 1);

   logic rx_meta, rx_sync;

   rx_state_t state, state_nxt;
   logic [3:0]            s, s_nxt;
   logic [2:0]            n, n_nxt;
   logic [DATA_WIDTH-1:0] b, b_nxt, data_nxt;
   logic                  done_nxt, err_nxt;

   br_generator #(
      .FREQ      (FREQ),
      .BAUD_RATE (BAUD_RATE),
      .N         (N)
   ) u_br_generator (
      .clk    (clk),
      .reset  (reset),
      .o_tick (o_tick)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         s           <= '0;
         n           <= '0;
         b           <= '0;
         o_data_byte <= '0;
         o_rx_done   <= 1'b0;
         o_frame_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         s           <= s_nxt;
         n           <= n_nxt;
         b           <= b_nxt;
         o_data_byte <= data_nxt;
         o_rx_done   <= done_nxt;
         o_frame_err <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      s_nxt     = s;
      n_nxt     = n;
      b_nxt     = b;
      data_nxt  = o_data_byte;
      done_nxt  = 1'b0;
      err_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            // Start detection runs every clock so back-to-back frames re-arm at once.
            if (!rx_sync) begin
               state_nxt = START;
               s_nxt     = '0;
            end
         end
         START: begin
            if (o_tick) begin
               if (s == 4'd7) begin
                  if (!rx_sync) begin
                     state_nxt = DATA;
                     s_nxt     = '0;
                     n_nxt     = '0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  s_nxt = s + 4'd1;
               end
            end
         end
         DATA: begin
            if (o_tick) begin
               if (s == 4'd15) begin
                  s_nxt = '0;
                  b_nxt = {rx_sync, b[DATA_WIDTH-1:1]};
                  if (n == LAST_BIT)
                     state_nxt = STOP;
                  else
                     n_nxt = n + 3'd1;
               end else begin
                  s_nxt = s + 4'd1;
               end
            end
         end
         STOP: begin
            if (o_tick) begin
               if (s == STOP_LAST) begin
                  // Byte is delivered even when the stop bit is bad.
                  data_nxt  = b;
                  done_nxt  = 1'b1;
                  err_nxt   = ~rx_sync;
                  state_nxt = IDLE;
               end else begin
                  s_nxt = s + 4'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: serial frames driven from a byte-level model,
// received bytes and framing flags compared against an expectation queue.
module tb_uart_receiver;

   localparam int unsigned FREQ     = 100_000_000;
   localparam int unsigned BAUD     = 1_250_000;
   localparam int unsigned DIV      = FREQ / (BAUD * 16);
   localparam int          BIT      = 16 * DIV;
   localparam int unsigned DEF_DIV  = 100_000_000 / (19_200 * 16);

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       rx_def = 1'b1;
   logic       tick, rx_done, frame_err;
   logic [7:0] data_byte;
   logic       tick_def, rx_done_def, frame_err_def;
   logic [7:0] data_byte_def;

   always #5 clk = ~clk;

   uart_receiver #(
      .FREQ       (FREQ),
      .BAUD_RATE  (BAUD),
      .N          (4),
      .DATA_WIDTH (8),
      .STOP_TICKS (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_rx        (rx),
      .o_tick      (tick),
      .o_rx_done   (rx_done),
      .o_data_byte (data_byte),
      .o_frame_err (frame_err)
   );

   uart_receiver dut_def (
      .clk         (clk),
      .reset       (reset),
      .i_rx        (rx_def),
      .o_tick      (tick_def),
      .o_rx_done   (rx_done_def),
      .o_data_byte (data_byte_def),
      .o_frame_err (frame_err_def)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected frames: {frame_err, byte}, pushed when a frame starts on the line.
   logic [8:0] exp_q[$];
   logic [8:0] mon_e;
   logic [7:0] exp_held = 8'h00;
   logic       prev_done = 1'b0;
   int         done_cnt = 0;
   bit         mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en) begin
         if (rx_done) begin
            done_cnt++;
            chk("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
               chk("spurious_done", {31'd0, rx_done}, 32'd0);
            end else begin
               mon_e    = exp_q.pop_front();
               exp_held = mon_e[7:0];
               chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e[8]});
            end
         end else begin
            chk("err_without_done", {31'd0, frame_err}, 32'd0);
         end
         chk("data_byte", {24'd0, data_byte}, {24'd0, exp_held});
         prev_done = rx_done;
         if (reset) exp_held = 8'h00;
      end
   end

   task automatic hold(input logic v, input int cycles);
      rx = v;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d, input logic stop_ok, input int bl);
      exp_q.push_back({~stop_ok, d});
      hold(1'b0, bl);
      for (int i = 0; i < 8; i++) hold(d[i], bl);
      if (stop_ok) begin
         hold(1'b1, bl);
      end else begin
         // Low past the mid-stop sample, then released so no phantom start survives.
         hold(1'b0, (bl * 3) / 4);
         hold(1'b1, bl - (bl * 3) / 4);
      end
   endtask

   task automatic measure_tick(input string tag, input int exp_period, input bit use_def);
      int cnt;
      cnt = 0;
      while (!(use_def ? tick_def : tick) && cnt < 1000) begin
         @(negedge clk);
         cnt++;
      end
      chk({tag, "_found"}, {31'd0, use_def ? tick_def : tick}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         cnt = 1;
         chk({tag, "_width"}, {31'd0, use_def ? tick_def : tick}, 32'd0);
         while (!(use_def ? tick_def : tick) && cnt < 1000) begin
            @(negedge clk);
            cnt++;
         end
         chk({tag, "_period"}, cnt, exp_period);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
      chk("drain", exp_q.size(), 32'd0);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int dc;
      logic [7:0] d;
      logic ok;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tick", {31'd0, tick}, 32'd0);
      chk("rst_done", {31'd0, rx_done}, 32'd0);
      chk("rst_err", {31'd0, frame_err}, 32'd0);
      chk("rst_byte", {24'd0, data_byte}, 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      measure_tick("tick_def", DEF_DIV, 1'b1);
      measure_tick("tick_fast", DIV, 1'b0);
      @(posedge clk);
      #1;

      hold(1'b1, BIT);
      send(8'hD6, 1'b1, BIT);
      hold(1'b1, BIT);
      drain();
      chk("d6_count", done_cnt, 32'd1);

      send(8'h55, 1'b1, BIT);
      send(8'hA3, 1'b1, BIT);
      hold(1'b1, BIT);
      drain();
      chk("b2b_count", done_cnt, 32'd3);

      dc = done_cnt;
      hold(1'b0, $urandom_range(3, 20));
      hold(1'b1, 2 * BIT);
      chk("glitch_no_done", done_cnt, dc);
      send(8'h3C, 1'b1, BIT);
      hold(1'b1, BIT);
      drain();

      send(8'h81, 1'b0, BIT);
      hold(1'b1, 2 * BIT);
      drain();
      chk("err_byte", {24'd0, data_byte}, 32'h81);

      d = 8'hA5;
      hold(1'b0, BIT);
      for (int i = 0; i < 4; i++) hold(d[i], BIT);
      hold(d[4], BIT / 2);
      reset = 1'b1;
      hold(1'b1, 2);
      reset = 1'b0;
      chk("rst_mid_byte", {24'd0, data_byte}, 32'd0);
      dc = done_cnt;
      hold(1'b1, 2 * BIT);
      chk("rst_mid_no_done", done_cnt, dc);
      send(8'hF0, 1'b1, BIT);
      hold(1'b1, BIT);
      drain();

      for (int f = 0; f < 12; f++) begin
         d  = 8'($urandom_range(0, 255));
         ok = ($urandom_range(0, 3) != 0);
         send(d, ok, ok ? $urandom_range(79, 81) : BIT);
         if (!ok)
            hold(1'b1, 2 * BIT);
         else if ($urandom_range(0, 1) == 1)
            hold(1'b1, $urandom_range(1, 160));
      end
      hold(1'b1, BIT);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
